seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
Parallel-to-serial front end that feeds the serial input `x` of the 101111 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on `x`, with a qualifying `x_valid` strobe. A one-word holding buffer lets consecutive words stream with no idle bit between them.

Parameters:
- WIDTH, 8: bits per word; legal range is 2 or more.
- MSB_FIRST, 1: shift order. 1 sends in_data[WIDTH-1] first; 0 sends in_data[0] first.
- IDLE_BIT, 0: level driven on `x` whenever no bit is being sent.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle; equals !pend_full (combinational).
- x  output  1  serial bit to the detector; registered.
- x_valid  output  1  x holds a real data bit this cycle; registered.
- busy  output  1  high when state==SHIFT or pend_full.

Behaviour:
- Handshake:
  - A word is accepted on a rising edge when in_valid && in_ready.
  - in_data may change freely when it is not being accepted.
- Internal state:
  - shift register sreg (WIDTH bits).
  - bit counter cnt, width clog2(WIDTH).
  - pending register pend with flag pend_full.
  - FSM with states IDLE and SHIFT.
- Reset (rst high at an edge):
  - state=IDLE, cnt=0, pend_full=0, x=IDLE_BIT, x_valid=0.
  - in_ready=1 from the following cycle.
  - Reset dominates in_valid; a word presented in the reset cycle is dropped.
  - Reset mid-word discards both the word in flight and the pending word; there is no partial flush.
- IDLE:
  - On accept: load sreg, drive the first bit on x, x_valid=1, cnt=WIDTH-1, go to SHIFT.
  - Latency: the first bit is visible from the accepting edge until the next edge (0-cycle registered latency).
- SHIFT, cnt>0 at an edge:
  - Present the next bit on x and decrement cnt.
  - An accept here writes pend and sets pend_full.
- SHIFT, cnt==0 (last bit on x) at an edge, in priority order:
  1. pend_full: move pend into sreg, present its first bit, cnt=WIDTH-1, clear pend_full. Stay in SHIFT with no gap.
  2. Else if accept this edge: bypass in_data straight into sreg the same way, with no gap; pend is untouched.
  3. Else: go to IDLE, x=IDLE_BIT, x_valid=0.
- Simultaneous events:
  - Drain of pend and a new accept cannot coincide, because in_ready=0 while pend_full.
  - A new word can be accepted in the cycle after pend drains.
- Throughput: exactly one bit per cycle while data is available. x_valid stays high for N*WIDTH consecutive cycles for N back-to-back words.
- Ordering: words leave in acceptance order; there is no reordering or duplication.
- Timing: x changes only on rising edges, so the downstream detector samples a stable bit one edge after launch.

Test Plan:
1. WIDTH=8, MSB_FIRST=1. After reset, accept 8'hBC once.
   - x must be 1,0,1,1,1,1,0,0 on 8 consecutive cycles starting at the accepting edge.
   - x_valid must be high for exactly those 8 cycles, then x=0, x_valid=0, busy=0.
2. Hold in_valid with 8'hA5 then 8'h3C.
   - 16 contiguous valid bits: 10100101 followed by 00111100.
   - in_ready low while pend_full; no gap cycle between the words.
3. Hold in_valid with a third word 8'hFF while pend is full.
   - Not accepted until the cycle after pend drains at the word boundary.
   - Output is 24 contiguous bits in order.
4. Present a word only in the cycle where cnt==0 and pend is empty.
   - Bypass load; x_valid must not drop between the words.
5. Assert rst for one cycle in the middle of the 4th bit of 8'hBC, with a pending word.
   - Next cycle: x=0, x_valid=0, in_ready=1, busy=0.
   - The pending word never appears.
   - The detector's z stays 0.
6. MSB_FIRST=0, send 8'h3D.
   - x must be 1,0,1,1,1,1,0,0, and the connected detector must pulse z=1 on the sixth bit.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: word-to-bit front end for the 101111 detector, with a one-word pending buffer for gapless streaming
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sreg, pend, src;
  logic [CW-1:0] cnt;
  logic pend_full, accept, last, load_pend, load_in, shift, store_pend;
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction
  function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w << 1 : w >> 1;
  endfunction
  assign in_ready = !pend_full;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SHIFT) || pend_full;
  assign last     = (cnt == '0);
  assign src      = load_pend ? pend : in_data;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb state_n = (load_pend || load_in || shift) ? SHIFT : IDLE;
  // cnt is only non-zero in SHIFT, so last also covers IDLE; accept implies pend is empty
  always_comb begin
    load_pend  = (state == SHIFT) && last && pend_full;
    load_in    = accept && last;
    shift      = (state == SHIFT) && !last;
    store_pend = accept && !last;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt       <= '0;
      pend_full <= 1'b0;
      x         <= IDLE_BIT;
      x_valid   <= 1'b0;
    end else begin
      if (load_pend || load_in) begin
        x       <= head(src);
        sreg    <= tail(src);
        x_valid <= 1'b1;
        cnt     <= CW'(WIDTH - 1);
      end else if (shift) begin
        x    <= head(sreg);
        sreg <= tail(sreg);
        cnt  <= cnt - CW'(1);
      end else begin
        x       <= IDLE_BIT;
        x_valid <= 1'b0;
      end
      if (store_pend) begin
        pend      <= in_data;
        pend_full <= 1'b1;
      end else if (load_pend) pend_full <= 1'b0;
    end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed checks of the serializer, with a 101111 detector model on the emitted stream
module tb_seq_bit_serializer;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] in_data = '0, in_data1 = '0;
  logic in_valid = 1'b0, in_valid1 = 1'b0;
  logic in_ready, x, x_valid, busy, in_ready1, x1, x_valid1, busy1;
  int total = 0, bad = 0;
  logic q[$];
  int runs[$];
  int run = 0;
  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .x_valid(x_valid), .busy(busy));
  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .x(x1), .x_valid(x_valid1), .busy(busy1));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (x_valid) begin
      q.push_back(x);
      run++;
    end else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
  function automatic logic [31:0] packq();
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction
  function automatic int zcount();
    logic [5:0] h = '0;
    int n = 0;
    foreach (q[i]) begin
      h = {h[4:0], q[i]};
      if (i >= 5 && h == 6'b101111) n++;
    end
    return n;
  endfunction
  task automatic clear_mon();
    @(posedge clk);
    q.delete();
    runs.delete();
  endtask
  task automatic push_word(input logic [7:0] w, output int waited);
    @(negedge clk);
    in_data = w;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
  endtask
  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    while ((busy || x_valid) && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (c >= 300) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%b x_valid=%b required 0", busy, x_valid);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if ({x, x_valid, in_ready, busy} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_state: x/xv/rdy/busy=%b required 0010", {x, x_valid, in_ready, busy});
    end
    clear_mon();
    repeat (4) @(negedge clk);
    total++;
    if (q.size() !== 0) begin
      bad++;
      $display("FAIL reset_drop: bits=%0d required 0", q.size());
    end
  endtask
  task automatic test_single();
    int wt;
    clear_mon();
    push_word(8'hBC, wt);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({x_valid, x} !== 2'b11) begin
      bad++;
      $display("FAIL single_latency: xv/x=%b required 11", {x_valid, x});
    end
    wait_idle();
    total++;
    if (q.size() !== 8 || packq() !== 32'hBC) begin
      bad++;
      $display("FAIL single_bits: n=%0d v=%h required n=8 v=bc", q.size(), packq());
    end
    total++;
    if (runs.size() !== 1 || runs[0] !== 8) begin
      bad++;
      $display("FAIL single_run: runs=%0d first=%0d required 1 run of 8", runs.size(), runs.size() ? runs[0] : -1);
    end
    total++;
    if ({x, x_valid, busy, in_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL single_end: x/xv/busy/rdy=%b required 0001", {x, x_valid, busy, in_ready});
    end
  endtask
  task automatic test_back_to_back();
    int wt;
    clear_mon();
    push_word(8'hA5, wt);
    push_word(8'h3C, wt);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({in_ready, busy} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_pend_full: rdy/busy=%b required 01", {in_ready, busy});
    end
    wait_idle();
    total++;
    if (q.size() !== 16 || packq() !== 32'hA53C || runs.size() !== 1 || runs[0] !== 16) begin
      bad++;
      $display("FAIL b2b_stream: n=%0d v=%h runs=%0d required n=16 v=a53c runs=1", q.size(), packq(), runs.size());
    end
  endtask
  task automatic test_three_words();
    int wt;
    clear_mon();
    push_word(8'hA5, wt);
    push_word(8'h3C, wt);
    push_word(8'hFF, wt);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (wt !== 7) begin
      bad++;
      $display("FAIL three_accept_wait: waited=%0d required 7", wt);
    end
    wait_idle();
    total++;
    if (q.size() !== 24 || packq() !== 32'hA53CFF || runs.size() !== 1 || runs[0] !== 24) begin
      bad++;
      $display("FAIL three_stream: n=%0d v=%h runs=%0d required n=24 v=a53cff runs=1", q.size(), packq(), runs.size());
    end
  endtask
  task automatic test_bypass();
    int wt;
    clear_mon();
    push_word(8'h5A, wt);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if ({in_ready, x_valid} !== 2'b11) begin
      bad++;
      $display("FAIL bypass_ready: rdy/xv=%b required 11", {in_ready, x_valid});
    end
    in_data = 8'hC3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({x_valid, x} !== 2'b11) begin
      bad++;
      $display("FAIL bypass_first: xv/x=%b required 11", {x_valid, x});
    end
    wait_idle();
    total++;
    if (q.size() !== 16 || packq() !== 32'h5AC3 || runs.size() !== 1 || runs[0] !== 16) begin
      bad++;
      $display("FAIL bypass_stream: n=%0d v=%h runs=%0d required n=16 v=5ac3 runs=1", q.size(), packq(), runs.size());
    end
  endtask
  task automatic test_reset_mid();
    int wt;
    clear_mon();
    push_word(8'hBC, wt);
    push_word(8'h81, wt);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({x, x_valid, in_ready, busy} !== 4'b0010) begin
      bad++;
      $display("FAIL midreset_state: x/xv/rdy/busy=%b required 0010", {x, x_valid, in_ready, busy});
    end
    repeat (20) @(negedge clk);
    total++;
    if (q.size() !== 4 || packq() !== 32'hB || runs.size() !== 1 || runs[0] !== 4) begin
      bad++;
      $display("FAIL midreset_stream: n=%0d v=%h runs=%0d required n=4 v=b runs=1", q.size(), packq(), runs.size());
    end
    total++;
    if (zcount() !== 0) begin
      bad++;
      $display("FAIL midreset_z: hits=%0d required 0", zcount());
    end
  endtask
  task automatic test_lsb_first();
    logic [7:0] got = '0;
    logic [5:0] h = '0;
    int vcnt = 0, zn = 0, zpos = -1;
    @(negedge clk);
    in_data1 = 8'h3D;
    in_valid1 = 1'b1;
    total++;
    if (in_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL lsb_ready: rdy=%b required 1", in_ready1);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      vcnt += int'(x_valid1);
      got = {got[6:0], x1};
      h = {h[4:0], x1};
      if (i >= 5 && h == 6'b101111) begin
        zn++;
        zpos = i;
      end
    end
    @(negedge clk);
    total++;
    if (got !== 8'b10111100 || vcnt !== 8 || x_valid1 !== 1'b0) begin
      bad++;
      $display("FAIL lsb_bits: bits=%b valid=%0d xv_after=%b required 10111100 8 0", got, vcnt, x_valid1);
    end
    total++;
    if (zn !== 1 || zpos !== 5) begin
      bad++;
      $display("FAIL lsb_z: hits=%0d at bit %0d required 1 at bit 5", zn, zpos);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_three_words();
    test_bypass();
    test_reset_mid();
    test_lsb_first();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
